serial_frame_rx: RTL

- Bit-serial frame receiver. It deserialises a framed stream on a single line into parallel words.
- Frame format: idle-high line, start bit 0, DATA_W data bits LSB first, one even-parity bit, stop bit 1.
- Presents each received word through a valid/ready output register, with parity, framing and overrun status.
- Sits at the receive end of the team's serial link. The downstream pipeline consumes words at its own pace.

---
 rtl/serial_rx_pkg.sv | 20 ++
 rtl/sync2.sv | 30 +++
 rtl/serial_frame_rx.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the serial frame receiver.
//   rx_state_t : receiver FSM states
//   half_of()  : half a bit period in clk cycles (start-bit mid-sample point)
`timescale 1ns/1ps
package serial_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_t;

  function automatic int unsigned half_of(int unsigned clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input.
// Both flops reset to 1 so an idle-high line reads as idle straight out of reset.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   d     : asynchronous input
//   q     : synchronised output
`timescale 1ns/1ps
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Bit-serial frame receiver: idle-high line, start 0, DATA_W data bits LSB first,
// even parity, stop 1. Each word is presented through a valid/ready output register.
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   din        : serial line (asynchronous, idles high)
//   out_data   : received word
//   out_valid  : held word not yet consumed
//   out_ready  : consumer takes the word this cycle
//   parity_err : parity mismatch for the held word
//   frame_err  : stop bit sampled 0 for the held word
//   overrun    : sticky, a completed frame was dropped because the output was full
`timescale 1ns/1ps
module serial_frame_rx
  import serial_rx_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned HALF = half_of(CLKS_PER_BIT);
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CntW-1:0] CntBitEnd  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalfEnd = CntW'(HALF - 1);
  localparam logic [IdxW-1:0] IdxLast    = IdxW'(DATA_W - 1);

  logic din_s;

  sync2 u_sync2 (
    .clk   (clk),
    .reset (reset),
    .d     (din),
    .q     (din_s)
  );

  rx_state_t         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              frame_done;
  logic              bit_tick;

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;

  // Receiver FSM: every sample after the start bit lands at mid-bit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    frame_done = 1'b0;
    bit_tick   = (cnt_q == CntBitEnd);

    case (state_q)
      StIdle: begin
        if (!din_s) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == CntHalfEnd) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = din_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (bit_tick) begin
          cnt_d          = '0;
          shift_d[idx_q] = din_s;
          if (idx_q == IdxLast) begin
            state_d = StParity;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StParity: begin
        if (bit_tick) begin
          cnt_d   = '0;
          par_d   = din_s;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_tick) begin
          cnt_d      = '0;
          frame_done = 1'b1;
          // A low stop bit parks in StBreak so a held-low line cannot retrigger.
          state_d    = din_s ? StIdle : StBreak;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBreak: begin
        if (din_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output register: a completing frame may replace a word consumed in the same cycle.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (frame_done) begin
      if (!valid_q || out_ready) begin
        data_d  = shift_q;
        perr_d  = (^shift_q) ^ par_q;
        ferr_d  = ~din_s;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule
